// File: rtl/fp_add_normalize_seq_if.sv
// Valid/ready bundle between the FP add pipeline's unnormalized-sum stage and
// the iterative normalizer, plus the packed-result return path.
interface fp_add_normalize_seq_if #(
    parameter int TAG_WIDTH = 6
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_add_significand;
    logic [7:0]           in_add_exponent;
    logic                 in_add_result_sign;
    logic                 in_logical_subtract;
    logic                 in_result_is_inf;
    logic                 in_result_is_nan;
    logic [TAG_WIDTH-1:0] in_tag;

    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_result;
    logic [TAG_WIDTH-1:0] out_tag;

    // Environment side: offers operations and consumes results.
    modport master (
        output in_valid, in_add_significand, in_add_exponent, in_add_result_sign,
               in_logical_subtract, in_result_is_inf, in_result_is_nan, in_tag,
        input  in_ready,
        input  out_valid, out_result, out_tag,
        output out_ready
    );

    // Normalizer side.
    modport slave (
        input  in_valid, in_add_significand, in_add_exponent, in_add_result_sign,
               in_logical_subtract, in_result_is_inf, in_result_is_nan, in_tag,
        output in_ready,
        output out_valid, out_result, out_tag,
        input  out_ready
    );
endinterface

// File: rtl/fp_add_normalize_seq.sv
// Single-lane iterative normalizer: shifts the unnormalized FP add sum by at most
// SHIFT_PER_CYCLE bits per cycle, then packs an IEEE-754 single-precision result.
module fp_add_normalize_seq #(
    parameter int SHIFT_PER_CYCLE = 4,
    parameter int TAG_WIDTH       = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    fp_add_normalize_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    localparam logic [30:0] INF_MAG   = 31'h7F80_0000;
    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam logic [4:0]  SHIFT_MAX = 5'(SHIFT_PER_CYCLE);

    state_t               state_q;
    logic                 out_valid_q;
    logic [31:0]          out_result_q;
    logic [TAG_WIDTH-1:0] out_tag_q;

    // Working copy of the operation being normalized.
    logic [24:0]          sig_q;
    logic signed [9:0]    exp_q;
    logic                 sign_q;
    logic                 sub_q;
    logic                 inf_q;
    logic                 nan_q;
    logic [TAG_WIDTH-1:0] tag_q;

    logic                 accept;
    logic [4:0]           lz;
    logic [4:0]           shift_amt;
    logic signed [9:0]    shift_exp;
    logic                 sig_zero;
    logic                 norm_finish;
    logic [31:0]          norm_result;
    logic [24:0]          next_sig;
    logic signed [9:0]    next_exp;
    logic                 unused_sig_hi;

    // Bits 31:25 of the incoming sum are guaranteed zero by the add pipeline.
    assign unused_sig_hi = |bus.in_add_significand[31:25];

    assign bus.in_ready   = (state_q == IDLE) && !reset;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;

    assign accept = bus.in_valid && bus.in_ready;

    function automatic logic [4:0] count_lz(input logic [23:0] s);
        logic [4:0] n;
        logic       found;
        n     = '0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (s[i]) found = 1'b1;
                else      n     = n + 5'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] pack(input logic             sign,
                                         input logic signed [9:0] e,
                                         input logic [22:0]      frac);
        if (e >= 10'sd255) return {sign, INF_MAG};
        else               return {sign, e[7:0], frac};
    endfunction

    // NOTE: every output of this block gets a default first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        lz          = count_lz(sig_q[23:0]);
        shift_amt   = (lz > SHIFT_MAX) ? SHIFT_MAX : lz;
        shift_exp   = $signed({5'd0, shift_amt});
        sig_zero    = (sig_q == '0);
        norm_finish = 1'b1;
        norm_result = '0;
        next_sig    = sig_q;
        next_exp    = exp_q;

        if (nan_q) begin
            norm_result = QNAN;
        end else if (inf_q) begin
            norm_result = {sign_q, INF_MAG};
        end else if (sig_zero || exp_q <= 10'sd0) begin
            // Exact cancellation x-x yields +0; underflow keeps the sign.
            norm_result = {sign_q && !(sig_zero && sub_q), 31'd0};
        end else if (sig_q[24]) begin
            // Rounding already happened upstream, so the shifted-out bit is dropped.
            norm_result = pack(sign_q, exp_q + 10'sd1, sig_q[23:1]);
        end else if (sig_q[23]) begin
            norm_result = pack(sign_q, exp_q, sig_q[22:0]);
        end else if (exp_q <= shift_exp) begin
            norm_result = {sign_q, 31'd0};
        end else begin
            norm_finish = 1'b0;
            next_sig    = sig_q << shift_amt;
            next_exp    = exp_q - shift_exp;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) state_q <= NORM;
                end
                NORM: begin
                    if (norm_finish) begin
                        out_result_q <= norm_result;
                        out_tag_q    <= tag_q;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the working registers carry no reset; they are always loaded on
    // accept before NORM reads them, and control state alone defines validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            sig_q  <= bus.in_add_significand[24:0];
            exp_q  <= $signed({2'b00, bus.in_add_exponent});
            sign_q <= bus.in_add_result_sign;
            sub_q  <= bus.in_logical_subtract;
            inf_q  <= bus.in_result_is_inf;
            nan_q  <= bus.in_result_is_nan;
            tag_q  <= bus.in_tag;
        end else if (state_q == NORM && !norm_finish) begin
            sig_q <= next_sig;
            exp_q <= next_exp;
        end
    end

endmodule

// File: tb/tb_fp_add_normalize_seq.sv
// Directed-vector bench for the iterative FP add normalizer (SHIFT_PER_CYCLE=4).
module tb_fp_add_normalize_seq;

    localparam int TW = 6;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    fp_add_normalize_seq_if #(.TAG_WIDTH(TW)) bus ();

    fp_add_normalize_seq #(
        .SHIFT_PER_CYCLE(4),
        .TAG_WIDTH      (TW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic [31:0] sig, input logic [7:0] e, input logic sign,
                         input logic sub, input logic inf, input logic nan,
                         input logic [TW-1:0] t);
        bus.in_add_significand  = sig;
        bus.in_add_exponent     = e;
        bus.in_add_result_sign  = sign;
        bus.in_logical_subtract = sub;
        bus.in_result_is_inf    = inf;
        bus.in_result_is_nan    = nan;
        bus.in_tag              = t;
        bus.in_valid            = 1'b1;
    endtask

    // Offers an operation and returns #1 after its accept edge (cycle 0).
    task automatic send(input logic [31:0] sig, input logic [7:0] e, input logic sign,
                        input logic sub, input logic inf, input logic nan,
                        input logic [TW-1:0] t);
        int waited = 0;
        drive(sig, e, sign, sub, inf, nan, t);
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic wait_result(input string tag, input logic [31:0] exp_res,
                               input logic [TW-1:0] exp_tag, input int exp_lat);
        wait_valid(tag, exp_lat);
        check({tag, "_res"}, bus.out_result, exp_res);
        check({tag, "_tag"}, 32'(bus.out_tag), 32'(exp_tag));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [31:0] sig, input logic [7:0] e,
                       input logic sign, input logic sub, input logic inf, input logic nan,
                       input logic [TW-1:0] t, input logic [31:0] exp_res, input int exp_lat);
        send(sig, e, sign, sub, inf, nan, t);
        wait_result(tag, exp_res, t, exp_lat);
    endtask

    initial begin
        logic seen_valid;
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        bus.out_ready = 1'b0;
        drive(32'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        bus.in_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_out_tag", 32'(bus.out_tag), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        //   tag        sig           exp     sgn   sub   inf   nan   tag     result        lat
        run("one_plus_one", 32'h0100_0000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0, 6'h11, 32'h4000_0000, 2);
        run("cancel_lz2",   32'h0020_0000, 8'd127, 1'b0, 1'b1, 1'b0, 1'b0, 6'h12, 32'h3E80_0000, 3);
        run("cancel_lz23",  32'h0000_0001, 8'd127, 1'b0, 1'b1, 1'b0, 1'b0, 6'h13, 32'h3400_0000, 8);
        run("exact_cancel", 32'h0000_0000, 8'd127, 1'b1, 1'b1, 1'b0, 1'b0, 6'h14, 32'h0000_0000, 2);
        run("zero_neg",     32'h0000_0000, 8'd127, 1'b1, 1'b0, 1'b0, 1'b0, 6'h15, 32'h8000_0000, 2);
        run("underflow",    32'h0000_0100, 8'd10,  1'b1, 1'b1, 1'b0, 1'b0, 6'h16, 32'h8000_0000, 4);
        run("overflow",     32'h0100_0000, 8'd254, 1'b0, 1'b0, 1'b0, 1'b0, 6'h17, 32'h7F80_0000, 2);
        run("nan",          32'h0080_0000, 8'd100, 1'b1, 1'b0, 1'b0, 1'b1, 6'h18, 32'h7FC0_0000, 2);
        run("inf_neg",      32'h0080_0000, 8'd100, 1'b1, 1'b0, 1'b1, 1'b0, 6'h19, 32'hFF80_0000, 2);
        run("normal_neg",   32'h00C0_0000, 8'd130, 1'b1, 1'b0, 1'b0, 1'b0, 6'h1A, 32'hC140_0000, 2);
        run("exp_zero",     32'h0080_0000, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 6'h1B, 32'h0000_0000, 2);
        run("exp255_pack",  32'h0080_0000, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 6'h1C, 32'h7F80_0000, 2);
        run("lz4_shift",    32'h0008_0000, 8'd127, 1'b0, 1'b1, 1'b0, 1'b0, 6'h1D, 32'h3D80_0000, 3);
        run("lz4_exp4",     32'h0008_0000, 8'd4,   1'b1, 1'b1, 1'b0, 1'b0, 6'h1E, 32'h8000_0000, 2);
        run("lz4_exp5",     32'h0008_0000, 8'd5,   1'b0, 1'b1, 1'b0, 1'b0, 6'h1F, 32'h0080_0000, 3);
        run("lz7_frac",     32'h0001_FFFF, 8'd127, 1'b0, 1'b1, 1'b0, 1'b0, 6'h20, 32'h3C7F_FF80, 4);
        run("carry_drop",   32'h0180_0001, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 6'h21, 32'h32C0_0000, 2);

        // Backpressure: hold the result 5 cycles while a second op waits.
        send(32'h0100_0000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0, 6'h2A);
        wait_valid("bp_first", 2);
        drive(32'h00C0_0000, 8'd130, 1'b1, 1'b0, 1'b0, 1'b0, 6'h2B);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_result", bus.out_result, 32'h4000_0000);
            check("bp_hold_tag", 32'(bus.out_tag), 32'h2A);
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_handoff_drop", 32'(bus.out_valid), 32'd0);
        check("bp_after_handoff_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_second_taken", 32'(bus.in_ready), 32'd0);
        wait_result("bp_second", 32'hC140_0000, 6'h2B, 2);

        // Reset during the second NORM cycle of the long cancellation case.
        send(32'h0000_0001, 8'd127, 1'b0, 1'b1, 1'b0, 1'b0, 6'h30);
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready_after", 32'(bus.in_ready), 32'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | bus.out_valid;
        end
        check("midrst_no_output", 32'(seen_valid), 32'd0);
        run("after_midrst", 32'h0020_0000, 8'd127, 1'b0, 1'b1, 1'b0, 1'b0, 6'h31, 32'h3E80_0000, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
